mc_cpu_control: RTL

Multi-cycle successor to the single-cycle control unit for the MIPS-subset CPU. It is a Moore/Mealy FSM that walks each instruction through IF/ID/EXE/MEM/WB. It issues the same datapath controls (aluc, shift, aluimm, sext, regrt, m2reg, jal, pcsource) plus per-state write strobes. It adds a ready/wait handshake to a shared instruction/data memory, an optional extended ISA, a memory timeout and an illegal-instruction flag.

---
 rtl/mc_cpu_pkg.sv | 78 +++++++
 rtl/mc_cpu_decode.sv | 143 ++++++++++++++
 rtl/mc_cpu_control.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/mc_cpu_pkg.sv
// Shared definitions for the multi-cycle MIPS-subset control unit:
// state encoding, opcode/function constants, ALU operation codes,
// PC source selector values and the decoded-instruction flag bundle.
package mc_cpu_pkg;

    // FSM states; the numeric values are visible on the state output
    typedef enum logic [2:0] {
        ST_IF  = 3'd0,
        ST_ID  = 3'd1,
        ST_EXE = 3'd2,
        ST_MEM = 3'd3,
        ST_WB  = 3'd4
    } state_e;

    // Primary opcodes
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    // R-type function codes
    localparam logic [5:0] FN_SLL = 6'b000000;
    localparam logic [5:0] FN_SRL = 6'b000010;
    localparam logic [5:0] FN_SRA = 6'b000011;
    localparam logic [5:0] FN_JR  = 6'b001000;
    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_XOR = 6'b100110;
    localparam logic [5:0] FN_NOR = 6'b100111;
    localparam logic [5:0] FN_SLT = 6'b101010;

    // ALU operation codes
    localparam logic [3:0] ALUC_ADD = 4'b0000;
    localparam logic [3:0] ALUC_AND = 4'b0001;
    localparam logic [3:0] ALUC_XOR = 4'b0010;
    localparam logic [3:0] ALUC_SLL = 4'b0011;
    localparam logic [3:0] ALUC_SUB = 4'b0100;
    localparam logic [3:0] ALUC_OR  = 4'b0101;
    localparam logic [3:0] ALUC_LUI = 4'b0110;
    localparam logic [3:0] ALUC_SRL = 4'b0111;
    localparam logic [3:0] ALUC_SLT = 4'b1000;
    localparam logic [3:0] ALUC_NOR = 4'b1001;
    localparam logic [3:0] ALUC_SRA = 4'b1111;

    // PC source mux selections
    localparam logic [1:0] PCS_SEQ    = 2'b00;
    localparam logic [1:0] PCS_BRANCH = 2'b01;
    localparam logic [1:0] PCS_RS     = 2'b10;
    localparam logic [1:0] PCS_JUMP   = 2'b11;

    // Memory wait counter width (TIMEOUT is limited to 1..255)
    localparam int unsigned          WAIT_W   = 8;
    localparam logic [WAIT_W-1:0]    WAIT_MAX = {WAIT_W{1'b1}};

    // Instruction classes the FSM sequences differently; plain ALU
    // instructions are the legal ones with none of these set.
    typedef struct packed {
        logic lw;
        logic sw;
        logic beq;
        logic bne;
        logic j;
        logic jal;
        logic jr;
    } instr_flags_t;

endpackage

// File: rtl/mc_cpu_decode.sv
// Combinational instruction decoder for the multi-cycle control unit.
// Produces the FSM sequencing flags, the static datapath controls and
// the illegal-instruction indication from op/func.
// Ports:
//   op, func  : instruction opcode and function fields
//   flags     : sequencing class (lw/sw/beq/bne/j/jal/jr)
//   aluc      : ALU operation code
//   shift, aluimm, sext, regrt, m2reg, jal : static datapath controls
//   ill       : op/func combination is not decodable
module mc_cpu_decode
    import mc_cpu_pkg::*;
#(
    parameter bit EXT_ISA = 1'b1
) (
    input  logic [5:0]   op,
    input  logic [5:0]   func,
    output instr_flags_t flags,
    output logic [3:0]   aluc,
    output logic         shift,
    output logic         aluimm,
    output logic         sext,
    output logic         regrt,
    output logic         m2reg,
    output logic         jal,
    output logic         ill
);

    // Opcode/function decode; undecodable encodings leave every control at 0
    always_comb begin
        flags  = '0;
        aluc   = ALUC_ADD;
        shift  = 1'b0;
        aluimm = 1'b0;
        sext   = 1'b0;
        regrt  = 1'b0;
        ill    = 1'b0;
        case (op)
            OP_RTYPE: begin
                case (func)
                    FN_ADD: aluc = ALUC_ADD;
                    FN_SUB: aluc = ALUC_SUB;
                    FN_AND: aluc = ALUC_AND;
                    FN_OR:  aluc = ALUC_OR;
                    FN_XOR: aluc = ALUC_XOR;
                    FN_SLL: begin
                        aluc  = ALUC_SLL;
                        shift = 1'b1;
                    end
                    FN_SRL: begin
                        aluc  = ALUC_SRL;
                        shift = 1'b1;
                    end
                    FN_SRA: begin
                        aluc  = ALUC_SRA;
                        shift = 1'b1;
                    end
                    FN_JR:  flags.jr = 1'b1;
                    FN_SLT: begin
                        if (EXT_ISA) begin
                            aluc = ALUC_SLT;
                        end else begin
                            ill = 1'b1;
                        end
                    end
                    FN_NOR: begin
                        if (EXT_ISA) begin
                            aluc = ALUC_NOR;
                        end else begin
                            ill = 1'b1;
                        end
                    end
                    default: ill = 1'b1;
                endcase
            end
            OP_ADDI: begin
                aluc   = ALUC_ADD;
                aluimm = 1'b1;
                sext   = 1'b1;
                regrt  = 1'b1;
            end
            OP_SLTI: begin
                if (EXT_ISA) begin
                    aluc   = ALUC_SLT;
                    aluimm = 1'b1;
                    sext   = 1'b1;
                    regrt  = 1'b1;
                end else begin
                    ill = 1'b1;
                end
            end
            OP_ANDI: begin
                aluc   = ALUC_AND;
                aluimm = 1'b1;
                regrt  = 1'b1;
            end
            OP_ORI: begin
                aluc   = ALUC_OR;
                aluimm = 1'b1;
                regrt  = 1'b1;
            end
            OP_XORI: begin
                aluc   = ALUC_XOR;
                aluimm = 1'b1;
                regrt  = 1'b1;
            end
            OP_LUI: begin
                aluc   = ALUC_LUI;
                aluimm = 1'b1;
                regrt  = 1'b1;
            end
            OP_LW: begin
                flags.lw = 1'b1;
                aluc     = ALUC_ADD;
                aluimm   = 1'b1;
                sext     = 1'b1;
                regrt    = 1'b1;
            end
            OP_SW: begin
                flags.sw = 1'b1;
                aluc     = ALUC_ADD;
                aluimm   = 1'b1;
                sext     = 1'b1;
            end
            OP_BEQ: begin
                flags.beq = 1'b1;
                aluc      = ALUC_SUB;
                sext      = 1'b1;
            end
            OP_BNE: begin
                flags.bne = 1'b1;
                aluc      = ALUC_SUB;
                sext      = 1'b1;
            end
            OP_J:   flags.j   = 1'b1;
            OP_JAL: flags.jal = 1'b1;
            default: ill = 1'b1;
        endcase
    end

    assign m2reg = flags.lw;
    assign jal   = flags.jal;

endmodule

// File: rtl/mc_cpu_control.sv
// Multi-cycle control unit for the MIPS-subset CPU. Walks each
// instruction through IF/ID/EXE/MEM/WB, issues the datapath controls and
// per-state write strobes, handshakes with a shared memory via mem_rdy
// and aborts a stalled access after TIMEOUT wait cycles.
// Ports:
//   clk, rst        : clock and synchronous active-high reset
//   op, func, z     : instruction fields and ALU zero flag
//   mem_rdy         : memory access completes this cycle
//   state           : current FSM state (IF=0 .. WB=4)
//   rmem, wmem, iord: memory read/write requests and address select
//   irwr, pcwr      : IR and PC load strobes; pcsource selects the new PC
//   wreg            : register-file write strobe
//   aluc, shift, aluimm, sext, regrt, m2reg, jal : static datapath controls
//   done, ill       : end-of-instruction and illegal-instruction pulses
//   mem_err         : sticky memory-timeout flag
module mc_cpu_control
    import mc_cpu_pkg::*;
#(
    parameter bit          EXT_ISA       = 1'b1,
    parameter bit          MEM_HANDSHAKE = 1'b1,
    parameter int unsigned TIMEOUT       = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] op,
    input  logic [5:0] func,
    input  logic       z,
    input  logic       mem_rdy,
    output logic [2:0] state,
    output logic       rmem,
    output logic       wmem,
    output logic       iord,
    output logic       irwr,
    output logic       pcwr,
    output logic [1:0] pcsource,
    output logic       wreg,
    output logic       regrt,
    output logic       m2reg,
    output logic       jal,
    output logic       shift,
    output logic       aluimm,
    output logic       sext,
    output logic [3:0] aluc,
    output logic       done,
    output logic       ill,
    output logic       mem_err
);

    localparam bit                TIMEOUT_EN = (TIMEOUT != 32'd0);
    localparam logic [WAIT_W-1:0] TIMEOUT_C  = WAIT_W'(TIMEOUT);

    state_e            state_q, state_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic              mem_err_q, mem_err_d;

    instr_flags_t flags_s;
    logic         ill_dec_s;
    logic         rdy_s;
    logic         waiting_s;
    logic         timeout_s;

    logic       rmem_s, wmem_s, iord_s, irwr_s, pcwr_s, wreg_s, done_s, ill_s;
    logic [1:0] pcsource_s;

    mc_cpu_decode #(
        .EXT_ISA (EXT_ISA)
    ) u_decode (
        .op     (op),
        .func   (func),
        .flags  (flags_s),
        .aluc   (aluc),
        .shift  (shift),
        .aluimm (aluimm),
        .sext   (sext),
        .regrt  (regrt),
        .m2reg  (m2reg),
        .jal    (jal),
        .ill    (ill_dec_s)
    );

    // Without the handshake every memory access completes in one cycle
    assign rdy_s     = MEM_HANDSHAKE ? mem_rdy : 1'b1;
    assign waiting_s = ((state_q == ST_IF) || (state_q == ST_MEM)) && !rdy_s;
    // wait_cnt_q holds the not-ready cycles already spent; the access is
    // abandoned on the next one after TIMEOUT of them
    assign timeout_s = TIMEOUT_EN && waiting_s && (wait_cnt_q == TIMEOUT_C);

    // Next-state and per-state control decode
    always_comb begin
        state_d    = state_q;
        rmem_s     = 1'b0;
        wmem_s     = 1'b0;
        iord_s     = 1'b0;
        irwr_s     = 1'b0;
        pcwr_s     = 1'b0;
        pcsource_s = PCS_SEQ;
        wreg_s     = 1'b0;
        done_s     = 1'b0;
        ill_s      = 1'b0;
        case (state_q)
            ST_IF: begin
                if (timeout_s) begin
                    // Abandon the fetch: request dropped, nothing loaded
                    done_s  = 1'b1;
                    state_d = ST_IF;
                end else begin
                    rmem_s = 1'b1;
                    if (rdy_s) begin
                        irwr_s  = 1'b1;
                        pcwr_s  = 1'b1;
                        state_d = ST_ID;
                    end else begin
                        state_d = ST_IF;
                    end
                end
            end
            ST_ID: begin
                if (ill_dec_s) begin
                    ill_s   = 1'b1;
                    done_s  = 1'b1;
                    state_d = ST_IF;
                end else if (flags_s.j || flags_s.jal) begin
                    // jal links the already-incremented PC
                    pcwr_s     = 1'b1;
                    pcsource_s = PCS_JUMP;
                    wreg_s     = flags_s.jal;
                    done_s     = 1'b1;
                    state_d    = ST_IF;
                end else if (flags_s.jr) begin
                    pcwr_s     = 1'b1;
                    pcsource_s = PCS_RS;
                    done_s     = 1'b1;
                    state_d    = ST_IF;
                end else begin
                    state_d = ST_EXE;
                end
            end
            ST_EXE: begin
                if (flags_s.beq || flags_s.bne) begin
                    pcsource_s = PCS_BRANCH;
                    pcwr_s     = (flags_s.beq & z) | (flags_s.bne & ~z);
                    done_s     = 1'b1;
                    state_d    = ST_IF;
                end else if (flags_s.lw || flags_s.sw) begin
                    state_d = ST_MEM;
                end else begin
                    state_d = ST_WB;
                end
            end
            ST_MEM: begin
                iord_s = 1'b1;
                if (timeout_s) begin
                    // Abandon the data access; lw skips its write-back
                    done_s  = 1'b1;
                    state_d = ST_IF;
                end else begin
                    rmem_s = flags_s.lw;
                    wmem_s = flags_s.sw;
                    if (rdy_s) begin
                        if (flags_s.sw) begin
                            done_s  = 1'b1;
                            state_d = ST_IF;
                        end else begin
                            state_d = ST_WB;
                        end
                    end else begin
                        state_d = ST_MEM;
                    end
                end
            end
            ST_WB: begin
                wreg_s  = 1'b1;
                done_s  = 1'b1;
                state_d = ST_IF;
            end
            default: state_d = ST_IF;
        endcase
    end

    // Wait counter and sticky timeout flag
    always_comb begin
        if (waiting_s && !timeout_s) begin
            if (wait_cnt_q == WAIT_MAX) begin
                wait_cnt_d = wait_cnt_q;
            end else begin
                wait_cnt_d = wait_cnt_q + {{(WAIT_W-1){1'b0}}, 1'b1};
            end
        end else begin
            wait_cnt_d = {WAIT_W{1'b0}};
        end
        mem_err_d = mem_err_q | timeout_s;
    end

    // State, wait counter and error flag registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IF;
            wait_cnt_q <= {WAIT_W{1'b0}};
            mem_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            mem_err_q  <= mem_err_d;
        end
    end

    // Strobes are suppressed for the whole reset cycle, whatever state held
    assign rmem     = rmem_s & ~rst;
    assign wmem     = wmem_s & ~rst;
    assign irwr     = irwr_s & ~rst;
    assign pcwr     = pcwr_s & ~rst;
    assign wreg     = wreg_s & ~rst;
    assign done     = done_s & ~rst;
    assign ill      = ill_s  & ~rst;
    assign iord     = iord_s;
    assign pcsource = pcsource_s;
    assign state    = state_q;
    assign mem_err  = mem_err_q;

endmodule
